// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Sequencer between ALU issue and the unsigned iterative divider
//               core. Handles sign conversion, start/done handshake, the
//               divide-by-zero policy and result hold until consumed.
//               Optional last-result cache: DIV_SEQ_RESULT_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_dbz,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic             core_busy,
    input  logic             core_done,
    input  logic             core_valid,
    input  logic             core_dbz,
    input  logic [WIDTH-1:0] core_val,
    input  logic [WIDTH-1:0] core_rem
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_launch = 2'd1;
    localparam logic [1:0] c_wait   = 2'd2;
    localparam logic [1:0] c_resp   = 2'd3;

    logic [1:0]       r_state;
    logic             r_rem_sel;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_a_orig;

    logic             w_accept;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic             w_hit;
    logic [WIDTH-1:0] w_hit_data;
    logic             w_hit_dbz;
    logic             w_unused;

    // The core's own status flags are redundant with core_done here
    assign w_unused = ^{core_busy, core_valid};

    assign w_accept = req_valid & req_ready;
    assign w_sa     = req_op[1] & req_a[WIDTH-1];
    assign w_sb     = req_op[1] & req_b[WIDTH-1];
    assign w_abs_a  = w_sa ? -req_a : req_a;
    assign w_abs_b  = w_sb ? -req_b : req_b;

    // Both results are formed so a cache entry can serve DIV and REM alike
    assign w_q = core_dbz ? {WIDTH{1'b1}} : (r_neg_q ? -core_val : core_val);
    assign w_r = core_dbz ? r_a_orig      : (r_neg_r ? -core_rem : core_rem);

`ifdef DIV_SEQ_RESULT_CACHE_EN
    logic             r_c_valid;
    logic             r_c_signed;
    logic [WIDTH-1:0] r_c_a;
    logic [WIDTH-1:0] r_c_b;
    logic [WIDTH-1:0] r_c_q;
    logic [WIDTH-1:0] r_c_r;
    logic             r_c_dbz;
    logic             r_signed;
    logic [WIDTH-1:0] r_b_orig;

    assign w_hit      = r_c_valid & (r_c_a == req_a) & (r_c_b == req_b) &
                        (r_c_signed == req_op[1]);
    assign w_hit_data = req_op[0] ? r_c_r : r_c_q;
    assign w_hit_dbz  = r_c_dbz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_q      <= '0;
            r_c_r      <= '0;
            r_c_dbz    <= 1'b0;
            r_signed   <= 1'b0;
            r_b_orig   <= '0;
        end else begin
            if (r_state == c_idle && w_accept) begin
                r_signed <= req_op[1];
                r_b_orig <= req_b;
            end
            if (r_state == c_wait && core_done) begin
                r_c_valid  <= 1'b1;
                r_c_signed <= r_signed;
                r_c_a      <= r_a_orig;
                r_c_b      <= r_b_orig;
                r_c_q      <= w_q;
                r_c_r      <= w_r;
                r_c_dbz    <= core_dbz;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
    assign w_hit_dbz  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_idle;
            r_rem_sel  <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_a_orig   <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_dbz    <= 1'b0;
            core_start <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_rem_sel <= req_op[0];
                        r_a_orig  <= req_a;
                        r_neg_q   <= w_sa ^ w_sb;
                        r_neg_r   <= w_sa;
                        core_a    <= w_abs_a;
                        core_b    <= w_abs_b;
                        req_ready <= 1'b0;
                        if (w_hit) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= w_hit_data;
                            rsp_dbz   <= w_hit_dbz;
                            r_state   <= c_resp;
                        end else begin
                            core_start <= 1'b1;
                            r_state    <= c_launch;
                        end
                    end
                end
                c_launch: begin
                    core_start <= 1'b0;
                    r_state    <= c_wait;
                end
                c_wait: begin
                    if (core_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= r_rem_sel ? w_r : w_q;
                        rsp_dbz   <= core_dbz;
                        r_state   <= c_resp;
                    end
                end
                c_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= c_idle;
                    end
                end
                default: begin
                    core_start <= 1'b0;
                    rsp_valid  <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// Testbench for div_seq_ctrl: behavioural divider core plus a scoreboard of
// expected responses built from a reference model and a fixed vector table.
module tb_div_seq_ctrl;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_dbz;
    logic             core_start;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_busy;
    logic             core_done;
    logic             core_valid;
    logic             core_dbz;
    logic [WIDTH-1:0] core_val;
    logic [WIDTH-1:0] core_rem;

    always #5 clk = ~clk;

    div_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_dbz(rsp_dbz),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_busy(core_busy), .core_done(core_done), .core_valid(core_valid),
        .core_dbz(core_dbz), .core_val(core_val), .core_rem(core_rem)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_dbz;
        int          lat;
        int          hold;
    } vec_t;

    vec_t        vecs[14];
    logic [32:0] sb_q[$];
    logic [63:0] mag_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_starts = 0;
    int          cur_lat = 1;
    bit          spur_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        dbz = (b == 32'd0);
        if (dbz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[1]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {dbz, op[0] ? r : q};
    endfunction

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Behavioural unsigned divider core with a programmable latency
    initial begin : core_model
        logic [31:0] ca;
        logic [31:0] cb;
        logic [63:0] m;
        bit          aborted;
        core_busy = 0; core_done = 0; core_valid = 0; core_dbz = 0;
        core_val = '0; core_rem = '0;
        forever begin
            @(negedge clk);
            core_done = 0; core_valid = 0; core_dbz = 0;
            if (spur_req) begin
                spur_req  = 1'b0;
                core_done = 1; core_valid = 1;
                core_val  = 32'h1234; core_rem = 32'h5678;
            end else if (core_start) begin
                n_starts++;
                check("start_expected", 32'(mag_q.size() != 0), 32'd1);
                if (mag_q.size() != 0) begin
                    m = mag_q.pop_front();
                    check("core_a", core_a, m[63:32]);
                    check("core_b", core_b, m[31:0]);
                end
                ca = core_a; cb = core_b;
                core_busy = 1; aborted = 0;
                for (int k = 0; k < cur_lat; k++) begin
                    @(negedge clk);
                    if (rst) aborted = 1;
                end
                core_busy = 0;
                if (!aborted) begin
                    core_done = 1; core_valid = 1;
                    if (cb == 32'd0) begin
                        core_dbz = 1; core_val = 32'hFFFF_FFFF; core_rem = ca;
                    end else begin
                        core_val = ca / cb; core_rem = ca % cb;
                    end
                end
            end
        end
    end

    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_dbz,
                           input int lat, input int hold);
        int          cyc;
        int          n0;
        bit          stable;
        logic [31:0] held;
        logic [32:0] e;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        cur_lat   = lat;
        rsp_ready = (hold == 0);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        sb_q.push_back({exp_dbz, exp_d});
        mag_q.push_back({mag(op[1], a), mag(op[1], b)});
        n0 = n_starts;
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
        check("latency", cyc, lat + 2);
        if (hold > 0) begin
            held = rsp_data; stable = 1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (rsp_data !== held || !rsp_valid || req_ready) stable = 0;
            end
            check("hold_stable", 32'(stable), 32'd1);
            rsp_ready = 1'b1;
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rsp_data", rsp_data, e[31:0]);
            check("rsp_dbz", 32'(rsp_dbz), 32'(e[32]));
        end
        @(negedge clk);
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("start_count", n_starts - n0, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] e;
        int          n0;
        bit          seen;

        vecs[0]  = '{2'd0, 32'd100000000, 32'd3,  32'd33333333,    1'b0, 3, 0};
        vecs[1]  = '{2'd1, 32'd166,       32'd0,  32'd166,         1'b1, 1, 0};
        vecs[2]  = '{2'd0, 32'd166,       32'd0,  32'hFFFF_FFFF,   1'b1, 2, 0};
        vecs[3]  = '{2'd2, -32'sd7,       32'd2,  -32'sd3,         1'b0, 4, 0};
        vecs[4]  = '{2'd3, -32'sd7,       32'd2,  -32'sd1,         1'b0, 5, 0};
        vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2, 0};
        vecs[6]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,    1'b0, 1, 0};
        vecs[7]  = '{2'd2, 32'd7,         -32'sd2, -32'sd3,        1'b0, 3, 10};
        vecs[8]  = '{2'd3, 32'd7,         -32'sd2, 32'd1,          1'b0, 2, 0};
        vecs[9]  = '{2'd2, -32'sd7,       32'd0,  32'hFFFF_FFFF,   1'b1, 1, 0};
        vecs[10] = '{2'd3, -32'sd7,       32'd0,  32'hFFFF_FFF9,   1'b1, 3, 0};
        vecs[11] = '{2'd1, 32'd100,       32'd7,  32'd2,           1'b0, 4, 0};
        vecs[12] = '{2'd2, -32'sd8,       -32'sd2, 32'd4,          1'b0, 2, 0};
        vecs[13] = '{2'd0, 32'h8000_0000, 32'd2,  32'h4000_0000,   1'b0, 1, 0};

        rst = 1'b1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_dbz", 32'(rsp_dbz), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_core_b", core_b, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_dbz,
                    vecs[i].lat, vecs[i].hold);

        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
            e  = model(op, a, b);
            run_req(op, a, b, e[31:0], e[32], $urandom_range(1, 6), 0);
        end

        // Stray core_done in IDLE with rsp_ready already high
        rsp_ready = 1'b1; spur_req = 1'b1; seen = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid || !req_ready) seen = 1; end
        check("stray_done_ignored", 32'(seen), 32'd0);

        // Reset while the core is still computing
        cur_lat = 30;
        req_op = 2'd0; req_a = 32'd1000; req_b = 32'd10; req_valid = 1'b1;
        mag_q.push_back({32'd1000, 32'd10});
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_wait_req_ready", 32'(req_ready), 32'd1);
        check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mag_q.delete();
        n0 = n_starts; seen = 0;
        repeat (35) begin @(negedge clk); if (rsp_valid || core_start) seen = 1; end
        check("no_activity_after_rst", 32'(seen), 32'd0);
        check("no_start_after_rst", n_starts - n0, 32'd0);

        // Normal operation resumes after the reset
        run_req(2'd3, -32'sd9, 32'd4, -32'sd1, 1'b0, 2, 0);
        check("queue_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
